// File: rtl/iter_alu.sv
// -----------------------------------------------------------------------------
// iter_alu -- execute unit with single-cycle ALU and iterative shift-add MUL.
//
// Single-cycle ops (ADD, SUB, AND, ORR, EOR, ADC, SBC) write result/flags on
// the accept edge and pulse done in the following cycle. MUL retires
// RADIX_BITS multiplier bits per cycle and completes N = WIDTH/RADIX_BITS
// cycles after accept. While MUL runs, ready is low and start is ignored.
//
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-high reset
//   start     in   request valid, accepted when ready=1
//   op        in   3-bit opcode (ADD,SUB,AND,ORR,EOR,ADC,SBC,MUL)
//   flags_en  in   1 = update NZCV on completion
//   carry_in  in   C input for ADC/SBC
//   a, b      in   WIDTH-bit operands
//   ready     out  new request can be accepted
//   done      out  one-cycle completion pulse
//   result    out  registered result, held until next completion
//   flags     out  registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module iter_alu #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flags_en,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;
  // With N==1 the whole product is formed on the accept edge, so MUL
  // behaves like a single-cycle op and MULT is never entered.
  localparam bit MULTI = (N > 1);
  // The first partial product is folded into the accept edge, so MULT
  // performs the remaining N-1 iterations (counter N-2 down to 0).
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((N > 1) ? N - 2 : 0);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SBC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MULT} state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_mul_fen;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_inv_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_pp0;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Returns {V, C, sum[WIDTH-1:0]} of x + y + cin computed at WIDTH+1 bits.
  function automatic logic [WIDTH+1:0] add_cv(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
    logic [WIDTH:0] s;
    logic           v;
    s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    v = (x[MSB] == y[MSB]) && (s[MSB] != x[MSB]);
    return {v, s};
  endfunction

  // One radix digit times the multiplicand, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] partial(input logic [WIDTH-1:0]      m,
                                               input logic [RADIX_BITS-1:0] d);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (d[i]) s = s + (m << i);
    end
    return s;
  endfunction

  assign ready    = r_ready;
  assign done     = r_done;
  assign result   = r_result;
  assign flags    = r_flags;
  assign w_accept = start & r_ready;

  // Subtraction is a + ~b + carry; SUB forces carry 1, ADD forces 0.
  assign w_inv_b = (op == OP_SUB) || (op == OP_SBC);
  assign w_b_eff = w_inv_b ? ~b : b;
  assign w_cin   = (op == OP_SUB) ? 1'b1 :
                   ((op == OP_ADC) || (op == OP_SBC)) ? carry_in : 1'b0;
  assign w_sum   = add_cv(a, w_b_eff, w_cin);

  assign w_pp0      = partial(a, b[RADIX_BITS-1:0]);
  assign w_acc_next = r_acc + partial(r_mcand, r_mplier[RADIX_BITS-1:0]);

  always_comb begin
    w_res = '0;
    w_c   = r_flags[1];
    w_v   = r_flags[0];
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_sum[WIDTH+1];
      end
      OP_AND:  w_res = a & b;
      OP_ORR:  w_res = a | b;
      OP_EOR:  w_res = a ^ b;
      OP_MUL:  w_res = w_pp0;
      default: w_res = '0;
    endcase
  end

  // Control FSM and architectural outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_flags   <= 4'b0000;
      r_mul_fen <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if ((op == OP_MUL) && MULTI) begin
              r_state   <= S_MULT;
              r_ready   <= 1'b0;
              r_cnt     <= CNT_LOAD;
              r_mul_fen <= flags_en;
            end else begin
              r_result <= w_res;
              r_done   <= 1'b1;
              if (flags_en) r_flags <= {w_res[MSB], ~|w_res, w_c, w_v};
            end
          end
        end
        S_MULT: begin
          if (r_cnt == '0) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b1;
            r_result <= w_acc_next;
            // MUL leaves C and V untouched.
            if (r_mul_fen) r_flags[3:2] <= {w_acc_next[MSB], ~|w_acc_next};
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Multiplier datapath; contents only matter while MULT is active.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= a << RADIX_BITS;
      r_mplier <= b >> RADIX_BITS;
      r_acc    <= w_pp0;
    end else if (r_state == S_MULT) begin
      r_mcand  <= r_mcand << RADIX_BITS;
      r_mplier <= r_mplier >> RADIX_BITS;
      r_acc    <= w_acc_next;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// -----------------------------------------------------------------------------
// tb_iter_alu -- scoreboard bench for iter_alu.
// Two instances share operands: dut0 (RADIX_BITS=1) and dut4 (RADIX_BITS=4).
// Stimulus pushes the expected {result, flags, done cycle} from an arithmetic
// reference model; a negedge monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_iter_alu;

  localparam int W  = 32;
  localparam int N0 = 32;
  localparam int N4 = 8;

  logic         clk;
  logic         reset;
  logic         start0, start4;
  logic [2:0]   op;
  logic         flags_en, carry_in;
  logic [W-1:0] a, b;
  logic         ready0, done0, ready4, done4;
  logic [W-1:0] result0, result4;
  logic [3:0]   flags0, flags4;

  iter_alu #(.WIDTH(W), .RADIX_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op), .flags_en(flags_en),
    .carry_in(carry_in), .a(a), .b(b), .ready(ready0), .done(done0),
    .result(result0), .flags(flags0));

  iter_alu #(.WIDTH(W), .RADIX_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .flags_en(flags_en),
    .carry_in(carry_in), .a(a), .b(b), .ready(ready4), .done(done4),
    .result(result4), .flags(flags4));

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];
  logic [3:0] mfl0, mfl4;
  int busy0, busy4;
  int cyc;
  int n_checks, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the ARM rules.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic ci,
                                input logic fe, input logic [3:0] fin,
                                output logic [W-1:0] r, output logic [3:0] fout);
    longint ux, uy, uc, sx, sy, usum, ssum;
    logic [63:0] prod;
    logic c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c  = fin[1];
    v  = fin[0];
    r  = '0;
    case (o)
      3'd0, 3'd5: begin
        uc   = (o == 3'd5) ? longint'(ci) : 0;
        usum = ux + uy + uc;
        ssum = sx + sy + uc;
        r    = usum[W-1:0];
        c    = (usum >= 64'sd4294967296);
        v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
      3'd1, 3'd6: begin
        uc   = (o == 3'd1) ? 1 : longint'(ci);
        usum = ux - uy - 1 + uc;
        ssum = sx - sy - 1 + uc;
        r    = usum[W-1:0];
        c    = (usum >= 0);
        v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      default: begin
        prod = 64'(x) * 64'(y);
        r    = prod[W-1:0];
      end
    endcase
    fout = fe ? {r[W-1], (r == '0), c, v} : fin;
  endfunction

  task automatic push(input int inst);
    exp_t e;
    logic [W-1:0] r;
    logic [3:0] f;
    int c, lat;
    c = cyc + 1;
    if (inst == 0) begin
      model(op, a, b, carry_in, flags_en, mfl0, r, f);
      mfl0  = f;
      lat   = (op == 3'd7) ? N0 - 1 : 0;
      busy0 = c + lat;
      e = '{res: r, fl: f, cyc: c + lat};
      q0.push_back(e);
    end else begin
      model(op, a, b, carry_in, flags_en, mfl4, r, f);
      mfl4  = f;
      lat   = (op == 3'd7) ? N4 - 1 : 0;
      busy4 = c + lat;
      e = '{res: r, fl: f, cyc: c + lat};
      q4.push_back(e);
    end
  endtask

  // Called at a negedge with operands already set; drives start for one cycle.
  task automatic step(input bit s0, input bit s4);
    start0 = s0;
    start4 = s4;
    chk("ready0", ready0, cyc >= busy0);
    chk("ready4", ready4, cyc >= busy4);
    if (s0 && cyc >= busy0) push(0);
    if (s4 && cyc >= busy4) push(1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic set_in(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic ci, input logic fe);
    op = o; a = x; b = y; carry_in = ci; flags_en = fe;
  endtask

  // Reset asserted a few time units into a cycle, away from any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_result0", result0, 0);
    chk("rst_flags0",  flags0,  0);
    chk("rst_done0",   done0,   0);
    chk("rst_ready0",  ready0,  1);
    chk("rst_result4", result4, 0);
    chk("rst_flags4",  flags4,  0);
    chk("rst_ready4",  ready4,  1);
    q0.delete();
    q4.delete();
    mfl0 = 4'b0000;
    mfl4 = 4'b0000;
    busy0 = 0;
    busy4 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done0_unexpected: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("result0", result0, e.res);
        chk("flags0",  flags0,  e.fl);
        chk("done0_cycle", cyc, e.cyc);
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done4_unexpected: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk("result4", result4, e.res);
        chk("flags4",  flags4,  e.fl);
        chk("done4_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] spec_vals[5];
    spec_vals[0] = 32'h0000_0000;
    spec_vals[1] = 32'hFFFF_FFFF;
    spec_vals[2] = 32'h8000_0000;
    spec_vals[3] = 32'h7FFF_FFFF;
    spec_vals[4] = 32'h0000_0001;
    n_checks = 0; n_fail = 0; cyc = 0;
    busy0 = 0; busy4 = 0; mfl0 = 4'b0; mfl4 = 4'b0;
    reset = 1'b1; start0 = 1'b0; start4 = 1'b0;
    set_in(3'd0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // Async reset mid-cycle after a flag-setting op.
    set_in(3'd1, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    step(1'b1, 1'b1);
    idle(1);
    do_reset();

    // ADD wrap to zero.
    set_in(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle(2);

    // SUB then back-to-back ADC with carry.
    set_in(3'd1, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    set_in(3'd5, 32'h1, 32'h1, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    idle(1);

    // Prior NZCV=0011, then MUL with start held; ADD accepted in done cycle.
    set_in(3'd1, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    set_in(3'd7, 32'h0001_2345, 32'h100, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    set_in(3'd0, 32'h5, 32'h7, 1'b0, 1'b0);
    for (int i = 0; i < N0; i++) step(1'b1, 1'b0);
    idle(2);

    // Reset 10 cycles into a MUL: no done afterwards, then ORR.
    set_in(3'd7, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle(10);
    do_reset();
    idle(40);
    set_in(3'd3, 32'hF0, 32'h0F, 1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle(2);

    // Radix-4 instance: full-width MUL, then flags_en=0 with prior NZCV=1000.
    set_in(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(N4 + 1);
    set_in(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    set_in(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle(N4 + 1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom;
      set_in(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 100 && (q0.size() != 0 || q4.size() != 0); k++) idle(1);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q4", q4.size(), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
